// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared definitions for the bit-memory load path: bank count,
//            bank-select width and the loader state encoding.
// Ports    : (package - none)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  // Both the x and w memories are split into this many banks.
  localparam int NUM_BANKS = 4;

  // Width of a bank select; must cover NUM_BANKS.
  localparam int SEL_W = 2;

  // Loader states. Each memory write is an ACC (wait for a stream bit)
  // followed by a single WR cycle that pulses the write enable.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_X_ACC = 3'd1,
    ST_X_WR  = 3'd2,
    ST_W_ACC = 3'd3,
    ST_W_WR  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage : mem_pkg

`default_nettype wire

// File: rtl/mem_loader_bank_addr_ctr.sv
// ============================================================================
// Module   : bank_addr_ctr
// Purpose  : Bank/address walker for one banked bit memory. Steps through
//            addresses 0..DEPTH-1 of bank 0, then bank 1, and so on. After
//            the last address of the last bank it wraps back to bank 0,
//            address 0.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            clr             - synchronous clear of addr/sel to 0
//            inc             - advance one bit position
//            addr [AW-1:0]   - current bit address within the bank
//            sel  [SEL_W-1:0]- current bank select
//            last            - current position is the final bit of the
//                              final bank
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_addr_ctr
  import mem_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [AW-1:0]    addr,
  output logic [SEL_W-1:0] sel,
  output logic             last
);

  localparam logic [AW-1:0]    c_last_addr = AW'(DEPTH - 1);
  localparam logic [SEL_W-1:0] c_last_sel  = SEL_W'(NUM_BANKS - 1);

  logic w_addr_wrap;

  assign w_addr_wrap = (addr == c_last_addr);
  assign last        = w_addr_wrap && (sel == c_last_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      sel  <= '0;
    end else if (clr) begin
      addr <= '0;
      sel  <= '0;
    end else if (inc) begin
      if (w_addr_wrap) begin
        addr <= '0;
        sel  <= sel + 1'b1;
      end else begin
        addr <= addr + 1'b1;
      end
    end
  end

endmodule : bank_addr_ctr

`default_nettype wire

// File: rtl/mem_loader.sv
// ============================================================================
// Module   : mem_loader
// Purpose  : Bit-serial load controller for the banked activation (x) and
//            weight (w) bit memories. Accepts one bit per valid/ready
//            handshake and writes x banks 0..3 followed by w banks 0..3.
//            Every write is a setup (ACC) cycle followed by a one-cycle
//            write strobe (WR), so address and data are already stable
//            whenever the level-sensitive memories see we high.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            start             - begin a load (only honoured in IDLE)
//            in_valid, in_data - stream bit handshake (input side)
//            in_ready          - loader accepts a bit this cycle
//            data_in           - write data to the memory system
//            we_x, we_w        - write strobes (never both high)
//            address_x/_w      - bit address within the selected bank
//            sel_x/_w          - bank selects
//            busy              - high from leaving IDLE through DONE
//            done              - one-cycle pulse at load completion
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_loader
  import mem_pkg::*;
#(
  parameter int X_AW   = 10,
  parameter int W_AW   = 20,
  parameter int X_BITS = 1024,
  parameter int W_BITS = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_data,
  output logic             in_ready,
  output logic             data_in,
  output logic             we_x,
  output logic             we_w,
  output logic [X_AW-1:0]  address_x,
  output logic [W_AW-1:0]  address_w,
  output logic [SEL_W-1:0] sel_x,
  output logic [SEL_W-1:0] sel_w,
  output logic             busy,
  output logic             done
);

  state_t r_state;
  state_t w_next_state;

  logic w_accept;
  logic w_ctr_clr;
  logic w_x_inc;
  logic w_w_inc;
  logic w_x_last;
  logic w_w_last;

  // in_ready is a registered copy of "state is an ACC state", so this
  // handshake only ever fires in X_ACC / W_ACC.
  assign w_accept = in_valid && in_ready;

  // Counters restart on a fresh load and are returned to zero on the way
  // back to IDLE, so the memory-side outputs read 0 between loads.
  assign w_ctr_clr = ((r_state == ST_IDLE) && start) || (r_state == ST_DONE);

  // Addresses advance on the edge that ends the WR cycle, i.e. the same
  // edge at which we_* falls.
  assign w_x_inc = (r_state == ST_X_WR);
  assign w_w_inc = (r_state == ST_W_WR);

  // --------------------------------------------------------------------------
  // Address walkers
  // --------------------------------------------------------------------------
  bank_addr_ctr #(
    .AW    (X_AW),
    .DEPTH (X_BITS)
  ) u_x_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_ctr_clr),
    .inc   (w_x_inc),
    .addr  (address_x),
    .sel   (sel_x),
    .last  (w_x_last)
  );

  bank_addr_ctr #(
    .AW    (W_AW),
    .DEPTH (W_BITS)
  ) u_w_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_ctr_clr),
    .inc   (w_w_inc),
    .addr  (address_w),
    .sel   (sel_w),
    .last  (w_w_last)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_X_ACC;
        end
      end
      ST_X_ACC: begin
        if (w_accept) begin
          w_next_state = ST_X_WR;
        end
      end
      ST_X_WR: begin
        // last is evaluated on the position being written now, before
        // the counter advances at this edge.
        w_next_state = w_x_last ? ST_W_ACC : ST_X_ACC;
      end
      ST_W_ACC: begin
        if (w_accept) begin
          w_next_state = ST_W_WR;
        end
      end
      ST_W_WR: begin
        w_next_state = w_w_last ? ST_DONE : ST_W_ACC;
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs. Decoding the next state into flops keeps every
  // strobe aligned with the state it belongs to while leaving no
  // combinational path from the inputs to any output.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      we_x     <= 1'b0;
      we_w     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_in  <= 1'b0;
    end else begin
      in_ready <= (w_next_state == ST_X_ACC) || (w_next_state == ST_W_ACC);
      we_x     <= (w_next_state == ST_X_WR);
      we_w     <= (w_next_state == ST_W_WR);
      busy     <= (w_next_state != ST_IDLE);
      done     <= (w_next_state == ST_DONE);
      if (r_state == ST_DONE) begin
        data_in <= 1'b0;
      end else if (w_accept) begin
        data_in <= in_data;
      end
    end
  end

endmodule : mem_loader

`default_nettype wire

// File: tb/tb_mem_loader.sv
// ============================================================================
// Module   : tb_mem_loader
// Purpose  : Directed self-checking bench for mem_loader with X_BITS=4 and
//            W_BITS=8 (48 bits per load).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_loader;

  localparam int X_AW   = 3;
  localparam int W_AW   = 4;
  localparam int X_BITS = 4;
  localparam int W_BITS = 8;
  localparam int N_X    = 4 * X_BITS;
  localparam int N_W    = 4 * W_BITS;
  localparam int N_ALL  = N_X + N_W;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            in_valid;
  logic            in_data;
  logic            in_ready;
  logic            data_in;
  logic            we_x;
  logic            we_w;
  logic [X_AW-1:0] address_x;
  logic [W_AW-1:0] address_w;
  logic [1:0]      sel_x;
  logic [1:0]      sel_w;
  logic            busy;
  logic            done;

  int n_tests = 0;
  int n_fail  = 0;

  // Read-back model of the memory system and an ordered write log.
  bit xmem [4][X_BITS];
  bit wmem [4][W_BITS];
  int q_wr [$];
  int nx = 0;
  int nw = 0;
  int nd = 0;

  logic [N_ALL-1:0] stream;
  int acc_cnt;
  int done_cyc;
  int rdy_c1;
  int saved;

  logic [X_AW+1:0] prev_x   = '0;
  logic [W_AW+1:0] prev_w   = '0;
  logic            prev_wex = 1'b0;
  logic            prev_wew = 1'b0;

  mem_loader #(
    .X_AW   (X_AW),
    .W_AW   (W_AW),
    .X_BITS (X_BITS),
    .W_BITS (W_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .we_x      (we_x),
    .we_w      (we_w),
    .address_x (address_x),
    .address_w (address_w),
    .sel_x     (sel_x),
    .sel_w     (sel_w),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int enc(input int kind, input int sel, input int addr, input int data);
    return kind * 4096 + sel * 256 + addr * 2 + data;
  endfunction

  // Expected write i of a load: x bits first, bank-major, then w bits.
  function automatic int exp_enc(input int i);
    int j;
    if (i < N_X) return enc(0, i / X_BITS, i % X_BITS, int'(stream[i]));
    j = i - N_X;
    return enc(1, j / W_BITS, j % W_BITS, int'(stream[i]));
  endfunction

  function automatic logic [31:0] outs();
    return 32'({in_ready, data_in, we_x, we_w, address_x, address_w,
                sel_x, sel_w, busy, done});
  endfunction

  // Memory-side monitor: logs every strobe and checks that strobes are
  // exclusive, single-cycle and see the address set up a cycle earlier.
  always @(negedge clk) begin
    if (we_x === 1'b1) begin
      chk("we_excl", 32'(we_w), 32'd0);
      chk("wex_single", 32'(prev_wex), 32'd0);
      chk("ax_hold", 32'({sel_x, address_x}), 32'(prev_x));
      xmem[int'(sel_x)][int'(address_x)] = data_in;
      q_wr.push_back(enc(0, int'(sel_x), int'(address_x), int'(data_in)));
      nx++;
    end
    if (we_w === 1'b1) begin
      chk("wew_single", 32'(prev_wew), 32'd0);
      chk("aw_hold", 32'({sel_w, address_w}), 32'(prev_w));
      wmem[int'(sel_w)][int'(address_w)] = data_in;
      q_wr.push_back(enc(1, int'(sel_w), int'(address_w), int'(data_in)));
      nw++;
    end
    if (done === 1'b1) nd++;
    prev_x   = {sel_x, address_x};
    prev_w   = {sel_w, address_w};
    prev_wex = we_x;
    prev_wew = we_w;
  end

  // Runs one load. Cycle c is the cycle ending at the c-th rising edge
  // after the edge that samples start. Optional: a 6-cycle in_valid gap
  // after bit gap_bit-1 is accepted (1 WR cycle + 5 ACC cycles), a 2-cycle
  // start pulse after bit start_bit-1, or an early return after
  // abort_bit bits have been accepted.
  task automatic run_load(input int gap_bit, input int start_bit, input int abort_bit);
    int   cyc;
    int   gap_left;
    int   start_left;
    logic acc;
    acc_cnt    = 0;
    done_cyc   = 0;
    rdy_c1     = 0;
    nx         = 0;
    nw         = 0;
    nd         = 0;
    q_wr.delete();
    cyc        = 0;
    gap_left   = 0;
    start_left = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = stream[0];
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) rdy_c1 = int'(in_ready);
      if (done === 1'b1 && done_cyc == 0) done_cyc = cyc;
      if (gap_left > 0 && in_ready === 1'b1)
        chk("bp_hold", 32'({we_x, we_w, 2'(gap_bit / X_BITS), X_AW'(gap_bit % X_BITS),
                            data_in}),
            32'({2'b00, 2'(gap_bit / X_BITS), X_AW'(gap_bit % X_BITS), stream[gap_bit-1]}));
      acc = (in_valid === 1'b1) && (in_ready === 1'b1);
      @(posedge clk);
      #1;
      if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) in_valid = 1'b1;
      end
      if (start_left > 0) begin
        start_left--;
        if (start_left == 0) start = 1'b0;
      end
      if (acc) begin
        acc_cnt++;
        if (acc_cnt == abort_bit) return;
        if (acc_cnt == gap_bit) begin
          in_valid = 1'b0;
          gap_left = 6;
        end
        if (acc_cnt == start_bit) begin
          start      = 1'b1;
          start_left = 2;
        end
        in_data = (acc_cnt < N_ALL) ? stream[acc_cnt] : 1'b0;
      end
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_load(input int exp_done);
    chk("done_cycle", done_cyc, exp_done);
    chk("done_count", nd, 1);
    chk("rdy_latency", rdy_c1, 1);
    chk("bits_accepted", acc_cnt, N_ALL);
    chk("we_x_pulses", nx, N_X);
    chk("we_w_pulses", nw, N_W);
    chk("log_len", q_wr.size(), N_ALL);
    if (q_wr.size() > 16) begin
      chk("wrap_bit4", q_wr[4], enc(0, 1, 0, int'(stream[4])));
      chk("wrap_bit15", q_wr[15], enc(0, 3, 3, int'(stream[15])));
      chk("wrap_bit16", q_wr[16], enc(1, 0, 0, int'(stream[16])));
    end
    for (int i = 0; i < N_ALL && i < q_wr.size(); i++)
      chk($sformatf("wr%0d", i), q_wr[i], exp_enc(i));
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < X_BITS; a++)
        chk($sformatf("xmem_%0d_%0d", s, a), 32'(xmem[s][a]), 32'(stream[s*X_BITS+a]));
      for (int a = 0; a < W_BITS; a++)
        chk($sformatf("wmem_%0d_%0d", s, a), 32'(wmem[s][a]), 32'(stream[N_X+s*W_BITS+a]));
    end
    chk("idle_clear", outs(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 1'b0;

    // Asynchronous reset takes effect mid-cycle.
    #2 rst_n = 1'b0;
    #1 chk("rst_outs", outs(), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_we", q_wr.size(), 0);
    chk("rst_idle", outs(), 32'd0);

    // Full load, in_valid held high.
    stream = 48'hA5C3_96F0_1E7B;
    run_load(-1, -1, -1);
    check_load(97);

    // Backpressure: 5 idle X_ACC cycles before bit 6 (bank 1, addr 2).
    stream = 48'h3C5A_0FF0_9D62;
    run_load(6, -1, -1);
    check_load(102);

    // start held through W_WR/W_ACC around bit 21 must not restart.
    stream = 48'hF00D_BEEF_1234;
    run_load(-1, 21, -1);
    check_load(97);
    repeat (5) @(negedge clk);
    chk("no_restart_busy", 32'(busy), 32'd0);
    chk("no_restart_done", nd, 1);

    // Reset mid-load after 10 bits, then a clean reload.
    stream = 48'h1234_5678_9ABC;
    run_load(-1, -1, 10);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("abort_rst_outs", outs(), 32'd0);
    saved = q_wr.size();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_we", q_wr.size(), saved);
    chk("abort_idle", outs(), 32'd0);
    stream = 48'hC0FF_EE15_B00C;
    run_load(-1, -1, -1);
    if (q_wr.size() > 0)
      chk("restart_first", q_wr[0], enc(0, 0, 0, int'(stream[0])));
    check_load(97);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_loader

`default_nettype wire
